// File: rtl/ni_read_scheduler.sv
// Weighted round-robin read scheduler for per-app NI receive FIFOs with a 2-entry tagged output queue.
// Optional macro NI_SCHED_CRED_PRIO_EN gives app NUM_APPS-1 (credit FIFO) strict priority at grant time.
module ni_read_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_APPS     = 4,
  parameter int APP_BITS     = 2,
  parameter int QUANTUM_BITS = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ON,
  input  logic [NUM_APPS*QUANTUM_BITS-1:0] quantum_cfg,
  input  logic [NUM_APPS-1:0]              fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic [APP_BITS-1:0]              DEMUX,
  output logic                             fifo_rdEn,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [APP_BITS-1:0]              out_app,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic [1:0]                       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWITCH = 2'd1,
    S_BURST  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [APP_BITS-1:0]     demux_q, last_grant_q, pend_app_q;
  logic [QUANTUM_BITS-1:0] qcnt_q;
  logic                    pending_q;

  logic [DATA_WIDTH-1:0]   q_data_q [2];
  logic [APP_BITS-1:0]     q_app_q  [2];
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              count_q, count_d;

  logic                    grant_found;
  logic [APP_BITS-1:0]     grant_idx, cand;
  logic [QUANTUM_BITS-1:0] grant_quantum;
  logic                    credit_ok, bypass, store, deq;

  // Scan from the far end toward last_grant+1 so the nearest non-empty app wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = last_grant_q;
    for (int k = NUM_APPS; k >= 1; k--) begin
      cand = last_grant_q + APP_BITS'(k);
      if (!fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
`ifdef NI_SCHED_CRED_PRIO_EN
    if (!fifo_empty[NUM_APPS-1]) begin
      grant_found = 1'b1;
      grant_idx   = APP_BITS'(NUM_APPS-1);
    end
`else
`endif
    grant_quantum = quantum_cfg[grant_idx*QUANTUM_BITS +: QUANTUM_BITS];
  end

  // Queued words plus the word in flight never exceed the two queue slots.
  assign credit_ok = (3'(count_q) + 3'(pending_q)) < 3'd2;
  assign fifo_rdEn = (state_q == S_BURST) && ON && !fifo_empty[demux_q] && credit_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      demux_q      <= '0;
      last_grant_q <= APP_BITS'(NUM_APPS-1);
      qcnt_q       <= '0;
      pending_q    <= 1'b0;
      pend_app_q   <= '0;
    end else begin
      pending_q <= fifo_rdEn;
      if (fifo_rdEn) pend_app_q <= demux_q;
      case (state_q)
        S_IDLE: begin
          if (ON && grant_found) begin
            demux_q      <= grant_idx;
            last_grant_q <= grant_idx;
            qcnt_q       <= grant_quantum;
            state_q      <= S_SWITCH;
          end
        end
        S_SWITCH: state_q <= S_BURST;
        S_BURST: begin
          if (fifo_rdEn) begin
            if (qcnt_q == '0) state_q <= S_IDLE;
            else              qcnt_q  <= qcnt_q - QUANTUM_BITS'(1);
          end else if (fifo_empty[demux_q] || !ON) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output handshake: a head word transfers on any cycle where out_valid && out_ready;
  // out_valid never drops and out_data/out_app never change while the head waits.
  // The arriving word is forwarded straight to the head when the queue is empty.
  assign bypass    = pending_q && (count_q == 2'd0);
  assign out_valid = pending_q || (count_q != 2'd0);
  assign out_data  = bypass ? fifo_data  : q_data_q[rd_ptr_q];
  assign out_app   = bypass ? pend_app_q : q_app_q[rd_ptr_q];
  assign store     = pending_q && !(bypass && out_ready);
  assign deq       = out_valid && out_ready && (count_q != 2'd0);
  assign count_d   = count_q + 2'(store) - 2'(deq);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        q_data_q[i] <= '0;
        q_app_q[i]  <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (store) begin
        q_data_q[wr_ptr_q] <= fifo_data;
        q_app_q[wr_ptr_q]  <= pend_app_q;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assert property (@(posedge clk) disable iff (!reset) !(store && (count_q == 2'd2)));

  assign DEMUX       = demux_q;
  assign busy        = (state_q != S_IDLE) || pending_q || (count_q != 2'd0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ni_read_scheduler.sv
// Directed bench for ni_read_scheduler: FIFO bank model, tagged-word scoreboard and grant log.
`timescale 1ns/1ps
module tb_ni_read_scheduler;
  localparam int DW = 16;
  localparam int NA = 4;
  localparam int AB = 2;
  localparam int QB = 3;
  localparam int W  = AB + DW;

  logic             clk = 1'b0;
  logic             reset, ON, out_ready;
  logic [NA*QB-1:0] quantum_cfg;
  logic [NA-1:0]    fifo_empty;
  logic [DW-1:0]    fifo_data;
  logic [AB-1:0]    DEMUX, out_app;
  logic             fifo_rdEn, out_valid, busy;
  logic [DW-1:0]    out_data;
  logic [1:0]       dbg_state;

  logic [W-1:0]  exp_q[$];
  logic [AB-1:0] grant_log[$];
  logic [DW-1:0] fmem [NA][64];
  int            wcnt [NA];
  int            rcnt [NA];
  int            nx   [NA];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            rd_count = 0;

  ni_read_scheduler #(.DATA_WIDTH(DW), .NUM_APPS(NA), .APP_BITS(AB), .QUANTUM_BITS(QB)) dut (
    .clk(clk), .reset(reset), .ON(ON), .quantum_cfg(quantum_cfg),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .DEMUX(DEMUX), .fifo_rdEn(fifo_rdEn),
    .out_data(out_data), .out_app(out_app), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before 400us");
    $fatal(1, "watchdog expired");
  end

  // FIFO bank model: data appears the cycle after the read strobe
  always_comb for (int i = 0; i < NA; i++) fifo_empty[i] = (wcnt[i] == rcnt[i]);
  always @(posedge clk) begin
    if (fifo_rdEn && !fifo_empty[DEMUX]) begin
      fifo_data    <= fmem[DEMUX][rcnt[DEMUX]];
      rcnt[DEMUX] <= rcnt[DEMUX] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      if (dbg_state == 2'd1) grant_log.push_back(DEMUX);
      if (fifo_rdEn) begin
        rd_count++;
        chk("rd_on_empty", 32'(fifo_empty[DEMUX]), 32'd0);
      end
      if (out_valid && out_ready) begin
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("sb_word", 32'({out_app, out_data}), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic load(input int app, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[app][wcnt[app]] = DW'($urandom_range(0, 65535));
      wcnt[app]++;
    end
  endtask

  task automatic push_exp(input int app, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({AB'(app), fmem[app][nx[app]]});
      nx[app]++;
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && (&fifo_empty) && dbg_state == 2'd0) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_grant(input string tag, input int idx, input int app);
    logic [AB-1:0] g;
    g = 'x;
    if (idx < grant_log.size()) g = grant_log[idx];
    chk(tag, 32'(g), 32'(app));
  endtask

  initial begin
    int gl, rc, ga;
    logic [DW-1:0] held;
    int bs_app [6] = '{0, 2, 0, 2, 0, 2};
    int bs_len [6] = '{2, 2, 2, 2, 1, 1};
    int order  [4] = '{3, 0, 1, 2};

    reset = 1'b0; ON = 1'b0; out_ready = 1'b0; quantum_cfg = {NA{3'd7}};
    repeat (2) @(negedge clk);
    chk("rst_demux", 32'(DEMUX), 0);
    chk("rst_rden", 32'(fifo_rdEn), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_app", 32'(out_app), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dbg_state), 0);
    reset = 1'b1; ON = 1'b1; out_ready = 1'b1;
    @(negedge clk);

    // single app, quantum larger than the FIFO contents
    load(0, 3); push_exp(0, 3); gl = grant_log.size();
    @(negedge clk);
    chk("t1_switch_state", 32'(dbg_state), 1);
    chk("t1_switch_demux", 32'(DEMUX), 0);
    chk("t1_switch_rden", 32'(fifo_rdEn), 0);
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_rden_burst", 32'(fifo_rdEn), 1);
    end
    @(negedge clk);
    chk("t1_rden_empty", 32'(fifo_rdEn), 0);
    @(negedge clk);
    chk("t1_back_idle", 32'(dbg_state), 0);
    wait_drain("t1_drain");
    chk_grant("t1_grant", gl, 0);

    // two apps, quantum 1 each: interleaved bursts
    do_reset();
    quantum_cfg = {NA{3'd1}};
    load(0, 5); load(2, 5); gl = grant_log.size();
    for (int i = 0; i < 6; i++) push_exp(bs_app[i], bs_len[i]);
    wait_drain("t2_drain");
    chk("t2_grant_count", 32'(grant_log.size() - gl), 6);
    for (int i = 0; i < 6; i++) chk_grant("t2_grant_order", gl + i, bs_app[i]);

    // back-pressure: only two words may be outstanding
    quantum_cfg = {NA{3'd7}};
    out_ready = 1'b0; rc = rd_count;
    load(1, 4); push_exp(1, 4);
    repeat (8) @(negedge clk);
    chk("t3_reads_stalled", 32'(rd_count - rc), 2);
    chk("t3_rden_low", 32'(fifo_rdEn), 0);
    chk("t3_valid", 32'(out_valid), 1);
    held = out_data;
    repeat (3) @(negedge clk);
    chk("t3_data_hold", 32'(out_data), 32'(held));
    chk("t3_app_hold", 32'(out_app), 1);
    out_ready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_reads_total", 32'(rd_count - rc), 4);

    // reset mid-burst with one queued word and one in flight
    out_ready = 1'b0;
    load(0, 3);
    @(negedge clk);
    chk("t4_grant_demux", 32'(DEMUX), 0);
    load(1, 1);
    @(negedge clk);
    chk("t4_read1", 32'(fifo_rdEn), 1);
    @(negedge clk);
    chk("t4_read2", 32'(fifo_rdEn), 1);
    @(negedge clk);
    chk("t4_pre_valid", 32'(out_valid), 1);
    chk("t4_pre_rden", 32'(fifo_rdEn), 0);
    reset = 1'b0;
    #1;
    chk("t4_async_valid", 32'(out_valid), 0);
    chk("t4_async_demux", 32'(DEMUX), 0);
    chk("t4_async_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t4_held_valid", 32'(out_valid), 0);
    chk("t4_held_data", 32'(out_data), 0);
    reset = 1'b1;
    exp_q.delete();
    nx[0] += 2;
    push_exp(0, 1); push_exp(1, 1);
    gl = grant_log.size();
    out_ready = 1'b1;
    wait_drain("t4_drain");
    chk_grant("t4_first_grant", gl, 0);
    chk_grant("t4_second_grant", gl + 1, 1);

    // enable gating: no grants while ON is low, then ON dropped mid-burst
`ifdef NI_SCHED_CRED_PRIO_EN
    ga = 3;
`else
    ga = 2;
`endif
    ON = 1'b0;
    for (int a = 0; a < NA; a++) load(a, 1);
    load(ga, 3);
    gl = grant_log.size(); rc = rd_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_off_rden", 32'(fifo_rdEn), 0);
      chk("t5_off_state", 32'(dbg_state), 0);
    end
    chk("t5_off_nogrant", 32'(grant_log.size() - gl), 0);
    ON = 1'b1;
    @(negedge clk);
    chk("t5_grant_demux", 32'(DEMUX), 32'(ga));
    @(negedge clk);
    chk("t5_first_read", 32'(fifo_rdEn), 1);
    push_exp(ga, 1);
    @(negedge clk);
    ON = 1'b0;
    #1;
    chk("t5_drop_rden", 32'(fifo_rdEn), 0);
    chk("t5_inflight_valid", 32'(out_valid), 1);
    @(negedge clk);
    chk("t5_drop_idle", 32'(dbg_state), 0);
    repeat (4) @(negedge clk);
    chk("t5_drop_reads", 32'(rd_count - rc), 1);
    chk("t5_drop_grants", 32'(grant_log.size() - gl), 1);
    chk("t5_drop_sb_empty", 32'(exp_q.size()), 0);
    ON = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(order[i], wcnt[order[i]] - nx[order[i]]);
    wait_drain("t5_drain");

    // credit-FIFO priority versus plain round-robin from last_grant=3
    load(3, 1); push_exp(3, 1);
    wait_drain("t6_setup_drain");
    load(0, 1); load(3, 1); gl = grant_log.size();
`ifdef NI_SCHED_CRED_PRIO_EN
    push_exp(3, 1); push_exp(0, 1);
    wait_drain("t6_drain");
    chk_grant("t6_first_grant", gl, 3);
    chk_grant("t6_second_grant", gl + 1, 0);
`else
    push_exp(0, 1); push_exp(3, 1);
    wait_drain("t6_drain");
    chk_grant("t6_first_grant", gl, 0);
    chk_grant("t6_second_grant", gl + 1, 3);
`endif

    // final report
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_read_scheduler.md
Name: ni_read_scheduler

Overview:
- Weighted round-robin read scheduler for the per-application receive FIFOs of a network interface.
- Watches each app FIFO's empty flag, drives the FIFO select (DEMUX) and read enable, and bursts up to a programmable quantum of words from the granted app.
- Returned words go into a 2-entry output queue tagged with app ID; the core drains it through a valid/ready handshake.
- Sits between the NI FIFO bank and the core's receive port.

Parameters:
DATA_WIDTH, 16, FIFO word width
NUM_APPS, 4, number of app FIFOs (power of 2, >=2)
APP_BITS, 2, log2(NUM_APPS)
QUANTUM_BITS, 3, width of each per-app quantum field

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
ON  input  1  enable; low blocks new grants and new reads
quantum_cfg  input  NUM_APPS*QUANTUM_BITS  per-app quantum q; field i = bits [i*QUANTUM_BITS +: QUANTUM_BITS]; burst length = q+1
fifo_empty  input  NUM_APPS  per-app empty flags, bit i = app i
fifo_data  input  DATA_WIDTH  selected FIFO read data, valid 1 cycle after fifo_rdEn
DEMUX  output  APP_BITS  FIFO select
fifo_rdEn  output  1  read strobe to selected FIFO
out_data  output  DATA_WIDTH  head of output queue
out_app  output  APP_BITS  app ID of head word
out_valid  output  1  head valid
out_ready  input  1  core accepts head when out_valid && out_ready
busy  output  1  state != IDLE, or a read is in flight, or queue not empty

Behaviour:
- Reset (async, reset=0) values: state=IDLE, DEMUX=0, fifo_rdEn=0, out_valid=0, out_data=0, out_app=0, busy=0, last_grant=NUM_APPS-1, queue count=0, pending=0. A reset mid-burst discards queued and in-flight words.
- IDLE: if ON=1 and any fifo_empty bit is 0, pick the first non-empty app scanning last_grant+1, +2, ... modulo NUM_APPS. Register grant into DEMUX and last_grant, load qcnt = quantum_cfg[grant], go to SWITCH. Otherwise stay in IDLE.
- SWITCH: one bubble cycle with fifo_rdEn=0 so DEMUX settles. Always go to BURST next.
- BURST:
  - fifo_rdEn = ON && !fifo_empty[DEMUX] && (count + pending < 2).
  - On each read: if qcnt==0, go to IDLE; otherwise decrement qcnt.
  - If fifo_empty[DEMUX]=1 or ON=0 and no read is issued this cycle, go to IDLE.
  - Unused quantum is forfeited.
- pending is a 1-bit register set to fifo_rdEn. When pending=1, push {DEMUX-at-issue, fifo_data} into the queue. The app tag is registered at issue, so a DEMUX change never mis-tags a word.
- Queue: 2-entry FIFO.
  - Push and pop in the same cycle is legal, count unchanged.
  - The credit rule guarantees no push when full; a push while full is an assertion failure.
  - out_* always present the head. out_data/out_app hold their value while out_valid && !out_ready.
- Throughput: with out_ready held high, one word per cycle in BURST.
- Grant overhead: 2 cycles (IDLE->SWITCH) per grant. Latency from fifo_rdEn to out_valid: 1 cycle.
- Simultaneous events: quantum exhaustion and the FIFO going empty on the same read both lead to IDLE. A word in flight when state leaves BURST is still captured.
- ON falling: reads in flight and queued words complete and drain normally.

Optional Feature:
- Macro NI_SCHED_CRED_PRIO_EN.
- Defined: app NUM_APPS-1 (credit FIFO) has strict priority in IDLE. If fifo_empty[NUM_APPS-1]=0 it is granted regardless of last_grant. last_grant still updates, so round-robin resumes from it afterwards.
- Undefined: pure round-robin for all apps, as above.

Test Plan:
- Reset, then app0 loaded with 3 words, q0=7, out_ready=1 -> DEMUX=0; rdEn high for 3 consecutive cycles starting at cycle 2 after grant; out_app=0 for all 3 words; then return to IDLE.
- Apps 0 and 2 each loaded with 5 words, q=1 for both, out_ready=1 -> grant order 0,2,0,2,0,2; bursts of 2,2,2,2,1,1 words; no words lost or reordered within an app.
- App1 loaded with 4 words, out_ready=0 -> exactly 2 reads issued, then rdEn held low. Raise out_ready -> remaining 2 words read; out_data stable while stalled.
- Assert reset (0) mid-burst with 1 queued word and 1 in flight -> next cycle out_valid=0 and DEMUX=0; after release, first grant goes to the lowest-index non-empty app.
- ON=0 with all FIFOs non-empty -> no grant, rdEn=0; ON dropped mid-burst -> in-flight word delivered, state returns to IDLE.
- NI_SCHED_CRED_PRIO_EN defined, apps 0 and 3 non-empty, last_grant=3 -> app3 is granted again before app0; with the macro undefined, app0 is granted.
